// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage pipeline: forwarding selects, load-use/branch stalls,
// multi-cycle MUL/DIV stall FSM and flush path. Define HAZARD_PERF_EN for stall counters.
module hazard_ctrl #(
  parameter int AW          = 5,
  parameter int MDU_LATENCY = 32,
  parameter int CW          = $clog2(MDU_LATENCY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rsD,
  input  logic [AW-1:0] rtD,
  input  logic [AW-1:0] rsE,
  input  logic [AW-1:0] rtE,
  input  logic [AW-1:0] writeregE,
  input  logic [AW-1:0] writeregM,
  input  logic [AW-1:0] writeregW,
  input  logic          regwriteE,
  input  logic          regwriteM,
  input  logic          regwriteW,
  input  logic          memtoregE,
  input  logic          memtoregM,
  input  logic          branchD,
  input  logic          mdu_startE,
  input  logic          flush_req,
  output logic [1:0]    forwardAE,
  output logic [1:0]    forwardBE,
  output logic          forwardAD,
  output logic          forwardBD,
  output logic          stallF,
  output logic          stallD,
  output logic          stallE,
  output logic          flushD,
  output logic          flushE,
  output logic          mdu_busy,
`ifdef HAZARD_PERF_EN
  output logic [31:0]   perf_lw,
  output logic [31:0]   perf_br,
  output logic [31:0]   perf_mdu,
`endif
  output logic          mdu_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic rsE_m, rsE_w, rtE_m, rtE_w;
  logic lwstall, branchstall, mdustall;
  logic br_dep_e, br_dep_m;

  // ---------------- MDU FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_req) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mdu_startE) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        BUSY: begin
          // The start cycle is the first stall cycle, so BUSY lasts MDU_LATENCY-1 cycles.
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = DONE;
        end
        DONE: begin
          if (mdu_startE) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------- hazard detection ----------------
  always_comb begin
    rsE_m = (rsE != '0) && (rsE == writeregM) && regwriteM;
    rsE_w = (rsE != '0) && (rsE == writeregW) && regwriteW;
    rtE_m = (rtE != '0) && (rtE == writeregM) && regwriteM;
    rtE_w = (rtE != '0) && (rtE == writeregW) && regwriteW;

    lwstall  = memtoregE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));
    br_dep_e = regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
    br_dep_m = memtoregM && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD));
    branchstall = branchD && (br_dep_e || br_dep_m);

    // A start accepted straight out of DONE also stalls its own launch cycle.
    mdustall = ((state_q == IDLE || state_q == DONE) && mdu_startE) || (state_q == BUSY);
  end

  // ---------------- outputs (all forced low while in reset) ----------------
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    mdu_busy  = 1'b0;
    mdu_done  = 1'b0;
    if (rst) begin
      forwardAE = rsE_m ? 2'b10 : (rsE_w ? 2'b01 : 2'b00);
      forwardBE = rtE_m ? 2'b10 : (rtE_w ? 2'b01 : 2'b00);
      forwardAD = (rsD != '0) && (rsD == writeregM) && regwriteM;
      forwardBD = (rtD != '0) && (rtD == writeregM) && regwriteM;
      mdu_busy  = (state_q == BUSY);
      mdu_done  = (state_q == DONE);
      if (flush_req) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (mdustall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
      end else if (lwstall || branchstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lw_q, perf_lw_d;
  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_mdu_q, perf_mdu_d;
  logic        win_lw, win_br, win_mdu;

  // When load-use and branch stalls coincide, load-use is credited.
  always_comb begin
    win_mdu    = !flush_req && mdustall;
    win_lw     = !flush_req && !mdustall && lwstall;
    win_br     = !flush_req && !mdustall && !lwstall && branchstall;
    perf_lw_d  = (win_lw  && (perf_lw_q  != '1)) ? perf_lw_q  + 32'd1 : perf_lw_q;
    perf_br_d  = (win_br  && (perf_br_q  != '1)) ? perf_br_q  + 32'd1 : perf_br_q;
    perf_mdu_d = (win_mdu && (perf_mdu_q != '1)) ? perf_mdu_q + 32'd1 : perf_mdu_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_lw_q  <= '0;
      perf_br_q  <= '0;
      perf_mdu_q <= '0;
    end else begin
      perf_lw_q  <= perf_lw_d;
      perf_br_q  <= perf_br_d;
      perf_mdu_q <= perf_mdu_d;
    end
  end

  assign perf_lw  = perf_lw_q;
  assign perf_br  = perf_br_q;
  assign perf_mdu = perf_mdu_q;
`else
  // Stall-cause counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MDU_LATENCY = 4.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, mdu_startE, flush_req;
  logic [1:0] forwardAE, forwardBE;
  logic       forwardAD, forwardBD, stallF, stallD, stallE, flushD, flushE;
  logic       mdu_busy, mdu_done;

  int total;
  int bad;

  hazard_ctrl #(.AW(5), .MDU_LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .mdu_startE(mdu_startE), .flush_req(flush_req),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    memtoregE = 1'b0; memtoregM = 1'b0;
    branchD = 1'b0; mdu_startE = 1'b0; flush_req = 1'b0;
  endtask

  // ---------------- checkers ----------------
  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // stallF, stallD, stallE, flushD, flushE checked together
  task automatic chk_ctl(input string tag, input logic sf, input logic sd, input logic se,
                         input logic fd, input logic fe);
    chk1({tag, ".stallF"}, stallF, sf);
    chk1({tag, ".stallD"}, stallD, sd);
    chk1({tag, ".stallE"}, stallE, se);
    chk1({tag, ".flushD"}, flushD, fd);
    chk1({tag, ".flushE"}, flushE, fe);
  endtask

  task automatic chk_all_zero(input string tag);
    chk2({tag, ".forwardAE"}, forwardAE, 2'b00);
    chk2({tag, ".forwardBE"}, forwardBE, 2'b00);
    chk1({tag, ".forwardAD"}, forwardAD, 1'b0);
    chk1({tag, ".forwardBD"}, forwardBD, 1'b0);
    chk_ctl(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1({tag, ".mdu_busy"}, mdu_busy, 1'b0);
    chk1({tag, ".mdu_done"}, mdu_done, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    total = 0;
    bad   = 0;
    clr();
    rst = 1'b0;
    // hazards present while in reset must not reach the outputs
    rsE = 5'd8; writeregM = 5'd8; regwriteM = 1'b1; mdu_startE = 1'b1; flush_req = 1'b1;
    rsD = 5'd8;
    #2;
    chk_all_zero("reset");
    tick();
    clr();
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("post_reset_idle");

    // ALU forwarding, M over W
    writeregM = 5'd8; regwriteM = 1'b1; writeregW = 5'd8; regwriteW = 1'b1;
    rsE = 5'd8; rtE = 5'd0;
    #1;
    chk2("fwd_m_prio.AE", forwardAE, 2'b10);
    chk2("fwd_m_prio.BE", forwardBE, 2'b00);
    regwriteM = 1'b0; rtE = 5'd8;
    #1;
    chk2("fwd_w.AE", forwardAE, 2'b01);
    chk2("fwd_w.BE", forwardBE, 2'b01);
    writeregM = 5'd0; writeregW = 5'd0; regwriteM = 1'b1; rsE = 5'd0; rtE = 5'd0;
    #1;
    chk2("fwd_r0.AE", forwardAE, 2'b00);
    chk2("fwd_r0.BE", forwardBE, 2'b00);
    rsD = 5'd0; rtD = 5'd0;
    #1;
    chk1("fwd_r0.AD", forwardAD, 1'b0);
    writeregM = 5'd8; rsD = 5'd8; rtD = 5'd3;
    #1;
    chk1("fwd_d.AD", forwardAD, 1'b1);
    chk1("fwd_d.BD", forwardBD, 1'b0);
    tick();
    clr();

    // load-use
    memtoregE = 1'b1; rtE = 5'd9; rsD = 5'd9;
    #1;
    chk_ctl("lwstall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    rtE = 5'd0;
    #1;
    chk_ctl("lw_r0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    clr();

    // branch after ALU op, then forwarded from M
    branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd4; rtD = 5'd4;
    #1;
    chk_ctl("br_alu", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    regwriteE = 1'b0; writeregE = 5'd0; writeregM = 5'd4; regwriteM = 1'b1;
    #1;
    chk_ctl("br_fwd", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("br_fwd.BD", forwardBD, 1'b1);
    memtoregM = 1'b1;
    #1;
    chk_ctl("br_load_m", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    clr();

    // MDU, latency 4, with a load-use hazard raised during BUSY
    mdu_startE = 1'b1;
    #1;
    chk_ctl("mdu_c0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk1("mdu_c0.busy", mdu_busy, 1'b0);
    tick();
    mdu_startE = 1'b0;
    #1;
    chk_ctl("mdu_c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk1("mdu_c1.busy", mdu_busy, 1'b1);
    tick();
    memtoregE = 1'b1; rtE = 5'd9; rsD = 5'd9;
    #1;
    chk_ctl("mdu_c2_lw", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_ctl("mdu_c3_lw", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk1("mdu_c3.done", mdu_done, 1'b0);
    tick();
    chk1("mdu_c4.done", mdu_done, 1'b1);
    chk1("mdu_c4.busy", mdu_busy, 1'b0);
    chk_ctl("mdu_c4_lw", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    clr();
    tick();
    chk1("mdu_c5.done", mdu_done, 1'b0);
    chk_ctl("mdu_c5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // flush mid-BUSY
    mdu_startE = 1'b1;
    tick();
    mdu_startE = 1'b0;
    tick();
    chk1("fl_pre.busy", mdu_busy, 1'b1);
    flush_req = 1'b1;
    #1;
    chk_ctl("fl_c2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    flush_req = 1'b0;
    #1;
    chk1("fl_c3.busy", mdu_busy, 1'b0);
    chk1("fl_c3.done", mdu_done, 1'b0);
    chk_ctl("fl_c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk1("fl_c4.done", mdu_done, 1'b0);

    // asynchronous reset between edges while BUSY
    mdu_startE = 1'b1;
    tick();
    mdu_startE = 1'b0;
    #1;
    chk1("ar_pre.busy", mdu_busy, 1'b1);
    chk1("ar_pre.stallE", stallE, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("ar_now");
    tick();
    chk_all_zero("ar_held");
    #2;
    rst = 1'b1;
    tick();
    tick();
    chk_all_zero("ar_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
